// File: rtl/arith_seq_pkg.sv
// Shared definitions for the sequential arithmetic blocks (square, square root).
package arith_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMP   = 2'd1,
    FINISH = 2'd2
  } seq_state_e;

endpackage

// File: rtl/square_sequential.sv
// Sequential squarer: shift-add of the captured operand against itself, one
// multiplier bit per cycle, with a valid/ready handshake on both sides.
module square_sequential
  import arith_seq_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N/2-1:0]   num,
  input  logic             i_valid,
  input  logic             i_ready,
  output logic [N-1:0]     res,
  output logic             o_valid,
  output logic             o_ready
);

  localparam int unsigned HALF    = N / 2;
  localparam int unsigned CNT_W   = $clog2(HALF);
  localparam int unsigned LAST_IT = HALF - 1;

  seq_state_e       state_q, state_d;
  logic [HALF-1:0]  mcand_q, mcand_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     res_d;
  logic             o_valid_d;
  logic             o_ready_d;

  logic [N-1:0]     acc_step;
  logic             last_iter;
  logic             in_xfer;
  logic             out_xfer;

  // One shift-add step: the operand is both multiplicand and multiplier.
  always_comb begin
    acc_step = acc_q;
    if (mcand_q[cnt_q]) begin
      acc_step = acc_q + (N'(mcand_q) << cnt_q);
    end
  end

  assign last_iter = (cnt_q == CNT_W'(LAST_IT));
  assign in_xfer   = i_valid && o_ready;
  assign out_xfer  = o_valid && i_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res     <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res     <= res_d;
      o_valid <= o_valid_d;
      o_ready <= o_ready_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_d     = res;
    o_valid_d = o_valid;
    o_ready_d = o_ready;

    case (state_q)
      IDLE: begin
        // o_ready re-arms here after reset; it drops on the accepting edge
        o_valid_d = 1'b0;
        o_ready_d = 1'b1;
        if (in_xfer) begin
          mcand_d   = num;
          acc_d     = '0;
          cnt_d     = '0;
          o_ready_d = 1'b0;
          state_d   = COMP;
        end
      end

      COMP: begin
        acc_d = acc_step;
        if (last_iter) begin
          res_d     = acc_step;
          o_valid_d = 1'b1;
          state_d   = FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FINISH: begin
        if (out_xfer) begin
          o_valid_d = 1'b0;
          o_ready_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        // Illegal encoding: recover quietly to IDLE without emitting a result
        o_valid_d = 1'b0;
        o_ready_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_square_sequential.sv
// Scoreboard bench for square_sequential: directed corner cases then random traffic.
module tb_square_sequential;

  localparam int unsigned N    = 16;
  localparam int unsigned HALF = N / 2;

  logic            clk;
  logic            reset;
  logic [HALF-1:0] num;
  logic            i_valid;
  logic            i_ready;
  logic [N-1:0]    res;
  logic            o_valid;
  logic            o_ready;

  square_sequential #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .num     (num),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .res     (res),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  typedef struct {
    logic [N-1:0]    sq;
    logic [HALF-1:0] op;
    int              acc_cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit ready_rand = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] ref_square(input logic [HALF-1:0] v);
    int unsigned a;
    int unsigned p;
    a = v;
    p = a * a;
    return N'(p);
  endfunction

  function automatic int ref_isqrt(input int unsigned x);
    int unsigned r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return int'(r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (ready_rand) i_ready = 1'($urandom_range(0, 1));
  endtask

  // Offer an operand until accepted; optionally keep i_valid high with junk afterwards.
  task automatic send(input logic [HALF-1:0] v, input int junk);
    bit accepted;
    accepted = 0;
    num     = v;
    i_valid = 1'b1;
    for (int k = 0; k < 200 && !accepted; k++) begin
      @(negedge clk);
      if (o_ready) begin
        sb.push_back('{ref_square(v), v, cyc + 1});
        accepted = 1;
      end
      tick();
    end
    chk("accept_timeout", 32'(accepted), 32'd1);
    chk("o_ready_cleared", 32'(o_ready), 32'd0);
    for (int j = 0; j < junk; j++) begin
      num = HALF'($urandom);
      tick();
    end
    i_valid = 1'b0;
    num     = HALF'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || !o_ready) && k < 400) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(k < 400), 32'd1);
  endtask

  // Monitor: pops the scoreboard on each output transfer and checks the hold rules.
  initial begin
    bit           was_valid;
    bit           after_pop;
    bit           hold;
    logic [N-1:0] last_res;
    logic [N-1:0] hold_res;
    exp_t         e;
    was_valid = 0;
    after_pop = 0;
    hold      = 0;
    last_res  = '0;
    hold_res  = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        was_valid = 0;
        after_pop = 0;
        hold      = 0;
      end else begin
        if (after_pop) begin
          chk("o_valid_single", 32'(o_valid), 32'd0);
          chk("res_retained", 32'(res), 32'(last_res));
          after_pop = 0;
        end
        if (hold) begin
          chk("hold_o_valid", 32'(o_valid), 32'd1);
          chk("hold_res", 32'(res), 32'(hold_res));
          hold = 0;
        end
        if (o_valid && !was_valid) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: res=%0d with nothing outstanding", res);
          end else begin
            chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(HALF));
          end
        end
        if (o_valid && i_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("square", 32'(res), 32'(e.sq));
          chk("sqrt_roundtrip", 32'(ref_isqrt(32'(res))), 32'(e.op));
          last_res  = res;
          after_pop = 1;
        end else if (o_valid) begin
          hold     = 1;
          hold_res = res;
        end
        was_valid = o_valid;
      end
    end
  end

  initial begin
    reset   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    num     = '0;

    // Reset held, then released
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_o_ready", 32'(o_ready), 32'd0);
      @(posedge clk);
    end
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("o_ready_after_release", 32'(o_ready), 32'd1);
    chk("o_valid_after_release", 32'(o_valid), 32'd0);
    tick();

    // Basic and boundary operands
    send(8'd13, 0);
    drain();
    chk("res_13", 32'(res), 32'd169);
    send(8'd0, 0);
    drain();
    chk("res_0", 32'(res), 32'd0);
    send(8'd255, 0);
    drain();
    chk("res_255", 32'(res), 32'h0000_FE01);
    send(8'd1, 0);
    drain();
    chk("res_1", 32'(res), 32'd1);

    // Downstream stall for 20 cycles
    i_ready = 1'b0;
    send(8'd200, 0);
    for (int k = 0; k < 50 && !o_valid; k++) @(negedge clk);
    chk("stall_o_valid_seen", 32'(o_valid), 32'd1);
    repeat (20) @(negedge clk);
    chk("stall_res", 32'(res), 32'd40000);
    tick();
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_release_o_valid", 32'(o_valid), 32'd0);
    chk("stall_release_o_ready", 32'(o_ready), 32'd1);
    tick();
    drain();

    // New operands offered during COMP must be ignored
    send(8'd99, HALF - 2);
    drain();
    chk("res_99", 32'(res), 32'd9801);

    // Reset in the middle of COMP aborts with no output
    send(8'd77, 0);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    sb.delete();
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(o_valid), 32'd0);
      tick();
    end
    drain();

    // Random back-to-back traffic with random downstream backpressure
    ready_rand = 1;
    for (int t = 0; t < 1000; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) tick();
      end
      send(HALF'($urandom), ($urandom_range(0, 7) == 0) ? int'(HALF - 2) : 0);
    end
    ready_rand = 0;
    i_ready    = 1'b1;
    drain();
    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/square_sequential.md
SQUARE_SEQUENTIAL -- requirements
Module: square_sequential

Interface
REQ-001 Parameter N, default 16: result width; SHALL be even and >= 4; operand width is N/2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clk edge).
REQ-004 num  input  N/2  unsigned operand to be squared.
REQ-005 i_valid  input  1  upstream asserts num is valid.
REQ-006 i_ready  input  1  downstream ready to take res.
REQ-007 res  output  N  unsigned result, num*num.
REQ-008 o_valid  output  1  res valid, held until taken.
REQ-009 o_ready  output  1  block can accept a new operand.

Function
REQ-010 Single-clock FSM with states IDLE, COMP, FINISH.
REQ-011 Input transfer occurs on an edge where i_valid && o_ready; num SHALL be captured into an internal multiplicand register, the accumulator and iteration counter cleared, state -> COMP.
REQ-012 o_ready SHALL be a register: 1 in IDLE, cleared on the input-transfer edge, set again on the edge returning to IDLE.
REQ-013 COMP: one shift-add iteration per cycle, LSB first; if the current multiplier bit is 1, add multiplicand shifted left by the iteration index to the N-bit accumulator; exactly N/2 iterations.
REQ-014 Arithmetic is unsigned; the accumulator is N bits wide and SHALL never overflow (max (2^(N/2)-1)^2 < 2^N).
REQ-015 On the edge completing iteration N/2: res <= accumulator, o_valid <= 1, state -> FINISH; o_valid first seen high N/2 cycles after the input-transfer edge (8 for N=16).
REQ-016 FINISH: res and o_valid held stable while i_ready==0, for any number of cycles.
REQ-017 Output transfer occurs on an edge where o_valid && i_ready; o_valid <= 0, state -> IDLE, o_ready <= 1; i_ready high before o_valid rises causes no early transfer.
REQ-018 res SHALL retain the last result after output transfer until the next result is loaded.
REQ-019 i_valid asserted while o_ready==0 SHALL be ignored; num changes during COMP SHALL not affect the result.
REQ-020 Minimum initiation interval: N/2+2 cycles (transfer, N/2 COMP, FINISH, IDLE re-arm).
REQ-021 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-022 On a reset edge: state IDLE, o_valid 0, o_ready 0, res 0, accumulator, multiplicand and counter 0.
REQ-023 o_ready SHALL rise on the first edge with reset==1 while in IDLE.
REQ-024 Reset during COMP or FINISH SHALL abort the operation with no o_valid pulse; the pending operand is discarded.

Structure
REQ-025 The state enum type (IDLE, COMP, FINISH, 2-bit) SHALL live in a shared package arith_seq_pkg, also used by the sequential square-root block.
REQ-026 The iteration counter width SHALL be $clog2(N/2), defined as a localparam in the module.
REQ-027 No sub-module; one flat module with the FSM and datapath.

Verification
REQ-028 Reset held 3 cycles, then released -> o_valid=0, res=0 throughout reset; o_ready=1 one edge after release.
REQ-029 N=16, num=8'd13, i_valid pulse, i_ready=1 -> o_valid high 8 cycles after acceptance, res=16'd169, single-cycle o_valid.
REQ-030 num=8'd0 -> res=0; num=8'd255 -> res=16'hFE01; num=8'd1 -> res=1.
REQ-031 num=8'd200 accepted, i_ready=0 for 20 cycles after o_valid -> res=16'd40000 and o_valid stable; i_ready=1 -> o_valid drops next edge, o_ready=1.
REQ-032 i_valid held high with new num values during COMP -> ignored, result matches the captured operand; reset asserted at iteration 4 -> IDLE, no o_valid.
REQ-033 Back-to-back random 1000 operands, chained into the sequential square-root block -> every square matches the reference model and the sqrt output equals the original num.
